// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared encodings and constants for the BCD display path
package bcd_display_pkg;
    localparam int BCD_W = 12;
    localparam logic [BCD_W-1:0] BCD_RESET = '0;
    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_t;
endpackage

// File: rtl/bcd_conversion_scheduler_if.sv
// bcd_conversion_scheduler_if: request, converter handshake and result bank of the scheduler
interface bcd_conversion_scheduler_if #(
    parameter int CHANNELS = 4,
    parameter int BINARY_DATA_SIZE = 8
);
    import bcd_display_pkg::*;
    logic [CHANNELS*BINARY_DATA_SIZE-1:0] channel_data;
    logic [CHANNELS-1:0] channel_req;
    logic conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic conv_start;
    logic [BINARY_DATA_SIZE-1:0] conv_binary;
    logic [CHANNELS*BCD_W-1:0] bcd_out;
    logic [CHANNELS-1:0] bcd_valid;
    logic busy;
    logic timeout_error;
    modport slave (
        input  channel_data, channel_req, conv_done, conv_bcd,
        output conv_start, conv_binary, bcd_out, bcd_valid, busy, timeout_error
    );
    modport master (
        output channel_data, channel_req, conv_done, conv_bcd,
        input  conv_start, conv_binary, bcd_out, bcd_valid, busy, timeout_error
    );
endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set pending bit searching from last_grant+1, wrapping around
module rr_priority_picker #(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0] pending,
    input  logic [$clog2(CHANNELS)-1:0] last_grant,
    output logic grant_valid,
    output logic [$clog2(CHANNELS)-1:0] grant_idx
);
    localparam int IW = $clog2(CHANNELS);
    logic [IW-1:0] j;
    // walk from farthest to nearest so the nearest set bit after last_grant wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx = '0;
        j = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            j = IW'((int'(last_grant) + k) % CHANNELS);
            if (pending[j]) begin
                grant_valid = 1'b1;
                grant_idx = j;
            end
        end
    end
endmodule

// File: rtl/bcd_conversion_scheduler.sv
// bcd_conversion_scheduler: round-robin sharing of one binary-to-BCD converter with a result bank and watchdog
module bcd_conversion_scheduler
    import bcd_display_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int BINARY_DATA_SIZE = 8,
    parameter int TIMEOUT = 32
) (
    input logic clk,
    input logic reset,
    bcd_conversion_scheduler_if.slave bus
);
    localparam int IW = $clog2(CHANNELS);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    state_t state_q, state_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [IW-1:0] cur_ch_q, cur_ch_d;
    logic [BINARY_DATA_SIZE-1:0] conv_binary_q, conv_binary_d;
    logic conv_start_q, conv_start_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [CHANNELS*BCD_W-1:0] bcd_out_q, bcd_out_d;
    logic [CHANNELS-1:0] bcd_valid_q, bcd_valid_d;
    logic busy_q;
    logic timeout_q, timeout_d;
    logic grant_valid;
    logic [IW-1:0] grant_idx;

    rr_priority_picker #(.CHANNELS(CHANNELS)) u_picker (
        .pending(pending_q),
        .last_grant(last_grant_q),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx)
    );

    // grant, launch and wait sequencing; a request on the granting edge re-arms pending
    always_comb begin
        state_d = state_q;
        pending_d = pending_q;
        last_grant_d = last_grant_q;
        cur_ch_d = cur_ch_q;
        conv_binary_d = conv_binary_q;
        conv_start_d = 1'b0;
        wd_d = wd_q;
        bcd_out_d = bcd_out_q;
        bcd_valid_d = bcd_valid_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_LAUNCH;
                    pending_d[grant_idx] = 1'b0;
                    last_grant_d = grant_idx;
                    cur_ch_d = grant_idx;
                    conv_binary_d = bus.channel_data[int'(grant_idx)*BINARY_DATA_SIZE +: BINARY_DATA_SIZE];
                    conv_start_d = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
                wd_d = '0;
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (bus.conv_done) begin
                    state_d = ST_IDLE;
                    bcd_out_d[int'(cur_ch_q)*BCD_W +: BCD_W] = bus.conv_bcd;
                    bcd_valid_d[cur_ch_q] = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_IDLE;
                    timeout_d = 1'b1;
                    bcd_valid_d[cur_ch_q] = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pending_d = pending_d | bus.channel_req;
    end

    // state and registered outputs; reset abandons any conversion in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pending_q <= '0;
            last_grant_q <= IW'(CHANNELS - 1);
            cur_ch_q <= '0;
            conv_binary_q <= '0;
            conv_start_q <= 1'b0;
            wd_q <= '0;
            bcd_out_q <= {CHANNELS{BCD_RESET}};
            bcd_valid_q <= '0;
            busy_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pending_q <= pending_d;
            last_grant_q <= last_grant_d;
            cur_ch_q <= cur_ch_d;
            conv_binary_q <= conv_binary_d;
            conv_start_q <= conv_start_d;
            wd_q <= wd_d;
            bcd_out_q <= bcd_out_d;
            bcd_valid_q <= bcd_valid_d;
            busy_q <= state_d != ST_IDLE;
            timeout_q <= timeout_d;
        end
    end

    assign bus.conv_start = conv_start_q;
    assign bus.conv_binary = conv_binary_q;
    assign bus.bcd_out = bcd_out_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.busy = busy_q;
    assign bus.timeout_error = timeout_q;
endmodule

// File: tb/tb_bcd_conversion_scheduler.sv
// tb_bcd_conversion_scheduler: directed and randomized checks against a transaction-level reference model
module tb_bcd_conversion_scheduler;
    import bcd_display_pkg::*;
    localparam int CH = 4;
    localparam int BW = 8;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bcd_conversion_scheduler_if #(.CHANNELS(CH), .BINARY_DATA_SIZE(BW)) bus ();
    bcd_conversion_scheduler #(.CHANNELS(CH), .BINARY_DATA_SIZE(BW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // converter stand-in: answers lat cycles after a start, can hang, or raise stray done levels
    int cv_cnt = 0;
    int cv_lat = 3;
    bit cv_hang = 0;
    bit cv_stale = 0;
    bit cv_noise = 0;
    always @(negedge clk) begin
        bus.conv_done = 1'b0;
        bus.conv_bcd = 12'($urandom);
        if (reset) cv_cnt = 0;
        else if (bus.conv_start) cv_cnt = cv_hang ? -1 : cv_lat;
        else if (cv_cnt > 1) cv_cnt--;
        else if (cv_cnt == 1) begin
            cv_cnt = 0;
            bus.conv_done = 1'b1;
            bus.conv_bcd = to_bcd(int'(bus.conv_binary));
        end
        if (cv_stale || (cv_noise && cv_cnt == 0 && $urandom_range(0, 7) == 0)) bus.conv_done = 1'b1;
    end

    // reference model: pending set, round-robin pick, conversion age since grant
    logic [CH-1:0] m_pend = '0;
    logic [CH-1:0] m_valid = '0;
    logic [11:0] m_bank [CH];
    logic [BW-1:0] m_bin = '0;
    int m_last = CH - 1;
    int m_ch = 0;
    int m_age = 0;
    bit m_active = 0;
    bit m_start = 0;
    bit m_terr = 0;
    always @(posedge clk) begin
        m_start = 0;
        if (reset) begin
            m_pend = '0;
            m_valid = '0;
            for (int i = 0; i < CH; i++) m_bank[i] = '0;
            m_bin = '0;
            m_last = CH - 1;
            m_active = 0;
            m_terr = 0;
        end else begin
            if (!m_active) begin
                for (int k = 1; k <= CH; k++) begin
                    if (m_pend[(m_last + k) % CH]) begin
                        m_ch = (m_last + k) % CH;
                        break;
                    end
                end
                if (m_pend != 0) begin
                    m_pend[m_ch] = 1'b0;
                    m_last = m_ch;
                    m_bin = bus.channel_data[m_ch*BW +: BW];
                    m_active = 1;
                    m_age = 0;
                    m_start = 1;
                end
            end else if (m_age == 0) m_age = 1;
            else if (bus.conv_done) begin
                m_bank[m_ch] = bus.conv_bcd;
                m_valid[m_ch] = 1'b1;
                m_active = 0;
            end else if (m_age == TO) begin
                m_terr = 1;
                m_valid[m_ch] = 1'b0;
                m_active = 0;
            end else m_age++;
            m_pend |= bus.channel_req;
        end
    end

    // per-cycle comparison of every output with the model, plus a start log
    bit chk_en = 0;
    int n_starts = 0;
    logic [BW-1:0] starts_q [$];
    logic [CH*12-1:0] exp_bank;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < CH; i++) exp_bank[i*12 +: 12] = m_bank[i];
            chk("conv_start", bus.conv_start, m_start);
            chk("conv_binary", bus.conv_binary, m_bin);
            chk("busy", bus.busy, m_active);
            chk("bcd_valid", bus.bcd_valid, m_valid);
            chk("timeout_error", bus.timeout_error, m_terr);
            chk("bcd_out", bus.bcd_out, exp_bank);
            if (bus.conv_start) begin
                n_starts++;
                starts_q.push_back(bus.conv_binary);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [CH-1:0] mask);
        bus.channel_req = mask;
        tick(1);
        bus.channel_req = '0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.conv_start && n < 40) begin
            tick(1);
            n++;
        end
        if (!bus.conv_start) chk(tag, 0, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((bus.busy || m_pend != 0 || m_active) && n < budget) begin
            tick(1);
            n++;
        end
        if (bus.busy || m_pend != 0 || m_active) chk(tag, 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int s0;
        int n;
        bus.channel_req = '0;
        bus.channel_data = '0;
        tick(2);
        reset = 1'b0;
        chk_en = 1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.bcd_valid, 0);
        chk("rst_bank", bus.bcd_out, 0);
        chk("rst_terr", bus.timeout_error, 0);
        chk("rst_start", bus.conv_start, 0);
        chk("rst_bin", bus.conv_binary, 0);

        cv_lat = 10;
        bus.channel_data[7:0] = 8'd200;
        s0 = n_starts;
        pulse(4'b0001);
        wait_idle("single_idle", 60);
        chk("single_starts", n_starts - s0, 1);
        chk("single_bcd", bus.bcd_out[11:0], 12'h200);
        chk("single_valid", bus.bcd_valid, 4'b0001);
        chk("single_busy", bus.busy, 0);

        do_reset();
        cv_lat = 4;
        bus.channel_data = {8'd255, 8'd128, 8'd99, 8'd0};
        starts_q.delete();
        pulse(4'b1111);
        wait_idle("rr_idle", 100);
        chk("rr_count", starts_q.size(), 4);
        if (starts_q.size() == 4) begin
            chk("rr_g0", starts_q[0], 8'd0);
            chk("rr_g1", starts_q[1], 8'd99);
            chk("rr_g2", starts_q[2], 8'd128);
            chk("rr_g3", starts_q[3], 8'd255);
        end
        chk("rr_bank", bus.bcd_out, {12'h255, 12'h128, 12'h099, 12'h000});
        chk("rr_valid", bus.bcd_valid, 4'b1111);

        cv_lat = 6;
        bus.channel_data[23:16] = 8'd50;
        starts_q.delete();
        pulse(4'b0100);
        wait_start("rereq_start");
        tick(2);
        bus.channel_data[23:16] = 8'd7;
        pulse(4'b0100);
        wait_idle("rereq_idle", 60);
        chk("rereq_count", starts_q.size(), 2);
        if (starts_q.size() == 2) begin
            chk("rereq_op0", starts_q[0], 8'd50);
            chk("rereq_op1", starts_q[1], 8'd7);
        end
        chk("rereq_bcd", bus.bcd_out[35:24], 12'h007);

        do_reset();
        cv_lat = 2;
        bus.channel_data[15:8] = 8'd42;
        bus.channel_req = 4'b0010;
        cv_stale = 1;
        tick(1);
        bus.channel_req = '0;
        tick(1);
        chk("stale_start", bus.conv_start, 1);
        tick(1);
        chk("stale_valid", bus.bcd_valid, 0);
        chk("stale_bank", bus.bcd_out, 0);
        cv_stale = 0;
        wait_idle("stale_idle", 40);
        chk("stale_bcd", bus.bcd_out[23:12], 12'h042);
        chk("stale_valid2", bus.bcd_valid, 4'b0010);

        cv_hang = 1;
        bus.channel_data[31:24] = 8'd250;
        pulse(4'b0010);
        wait_start("wd_start");
        n = 0;
        pulse(4'b1000);
        n++;
        cv_hang = 0;
        cv_lat = 5;
        while (!bus.timeout_error && n < 100) begin
            tick(1);
            n++;
        end
        chk("wd_cycles", n, TO + 1);
        chk("wd_valid", bus.bcd_valid, 4'b0000);
        chk("wd_slot", bus.bcd_out[23:12], 12'h042);
        chk("wd_busy", bus.busy, 0);
        wait_idle("wd_idle", 60);
        chk("wd_next_valid", bus.bcd_valid, 4'b1000);
        chk("wd_next_bcd", bus.bcd_out[47:36], 12'h250);
        chk("wd_sticky", bus.timeout_error, 1);

        do_reset();
        cv_lat = 8;
        bus.channel_data[7:0] = 8'd5;
        pulse(4'b0001);
        wait_start("rw_start");
        tick(2);
        pulse(4'b0100);
        s0 = n_starts;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rw_busy", bus.busy, 0);
        chk("rw_valid", bus.bcd_valid, 0);
        chk("rw_bank", bus.bcd_out, 0);
        chk("rw_bin", bus.conv_binary, 0);
        chk("rw_start", bus.conv_start, 0);
        chk("rw_terr", bus.timeout_error, 0);
        tick(14);
        chk("rw_nostart", n_starts, s0);
        chk("rw_valid2", bus.bcd_valid, 0);

        cv_noise = 1;
        for (int c = 0; c < 900; c++) begin
            bus.channel_req = CH'($urandom & $urandom);
            bus.channel_data = (CH*BW)'($urandom);
            cv_lat = $urandom_range(1, 12);
            cv_hang = $urandom_range(0, 30) == 0;
            reset = $urandom_range(0, 299) == 0;
            tick(1);
        end
        bus.channel_req = '0;
        reset = 1'b0;
        cv_hang = 0;
        cv_noise = 0;
        wait_idle("rand_idle", 400);
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
